bcd2bin_conv: RTL and testbench
===============================

// Module: bcd2bin_conv
// PURPOSE
//  Sequential BCD-to-binary converter for the calculator's bcd2bin core.
//  Uses the reverse double-dabble method: shift right one bit per cycle, then subtract 3
//  from every BCD digit that is >= 8.
//  Converts the packed BCD operand captured from the keypad path.
//  Drives the binary result and a one-cycle load strobe straight into the downstream
//  result registers (MSB/LSB holding registers), which capture on the falling clock edge.
// PARAMETERS
//  NDIG  2  number of packed BCD digits on bcd_in
//  BW    7  binary result width; must satisfy 2**BW >= 10**NDIG (sim-time assertion)
// PORTS
//  clk      in   1         clock; all state updates on the rising edge
//  reset    in   1         reset, synchronous, active-high
//  start    in   1         request conversion; sampled only in IDLE
//  bcd_in   in   4*NDIG    packed BCD operand; digit 0 in [3:0]; sampled on the accepted start
//  busy     out  1         high while in CONV or DONE
//  done     out  1         one-cycle pulse; result and err are valid
//  ld_out   out  1         one-cycle load strobe to the downstream register; identical timing to done
//  bin_out  out  BW        binary result; held until the next done
//  err      out  1         invalid digit (>9) seen at load; held until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, shift register=0.
//   Outputs: busy=0, done=0, ld_out=0, bin_out=0, err=0.
//  Reset mid-conversion aborts the operation on that edge. No done or ld_out is produced.
//  Datapath: sh[4*NDIG+BW-1:0] = {bcd_field, bin_field}.
//  FSM states:
//   IDLE: on start=1, validate every digit of bcd_in.
//    - All digits <=9: sh <= {bcd_in, BW'b0}, cnt <= 0, err <= 0, go to CONV.
//    - Any digit >9: err <= 1, bin_out <= 0, go to DONE. No conversion cycles.
//   CONV: each rising edge performs sh <= adj(sh >> 1) and cnt <= cnt+1.
//    - adj: every 4-bit digit of the bcd_field with value >= 8 gets 3 subtracted.
//      The bin_field passes through untouched.
//    - When cnt == BW-1 on an edge, that edge also loads bin_out from the shifted bin_field
//      and moves to DONE. CONV therefore lasts exactly BW cycles.
//   DONE: done=1 and ld_out=1 for exactly one cycle, then go to IDLE.
//    - ld_out is a registered output, so the downstream negedge register samples it half a
//      cycle after it rises, with stable data.
//  Latency: start accepted on edge k -> done high from edge k+BW+1 to edge k+BW+2.
//   With BW=7, done follows 8 edges after start.
//  start while busy=1 is ignored (no queuing). start held high re-triggers on the IDLE cycle
//   after DONE.
//  bcd_in may change after the accepted start edge without affecting the result.
//  After a full conversion the bcd_field of sh must be 0. Assert this in simulation.
//  Widths: cnt is $clog2(BW) bits. All arithmetic is unsigned, with no wrap inside a digit
//   because subtraction happens only when the digit is >= 8.
// STRUCTURE
//  Shared package bcd2bin_pkg:
//   - state localparams IDLE=2'd0, CONV=2'd1, DONE=2'd2
//   - default NDIG and BW
//   - function digit_valid(d) = (d <= 4'd9)
//  Sub-module bcd_digit_adj (4-bit in/out, combinational: out = in>=8 ? in-3 : in).
//   Instantiated NDIG times in a generate loop.
//  Top: FSM + counter + shift register + output registers, all in this file.
// TESTING
//  1. reset, start with bcd_in=8'h99 -> done pulses after 8 edges, bin_out=7'd99, err=0,
//     ld_out coincident with done.
//  2. bcd_in=8'h00 -> bin_out=0; bcd_in=8'h45 -> 7'd45; bcd_in=8'h10 -> 7'd10.
//     Sweep all 100 valid codes against a reference model.
//  3. bcd_in=8'h3A -> done after 1 cycle in DONE, err=1, bin_out=0.
//     The next valid start clears err.
//  4. Second start pulse at cycle 3 of CONV -> ignored: exactly one done,
//     result of the first operand.
//  5. reset asserted at cycle 4 of CONV -> next edge busy=0 and bin_out=0.
//     No done/ld_out; a fresh start then converts 8'h27 -> 7'd27.
//  6. start held high continuously with bcd_in=8'h12 -> back-to-back conversions,
//     one done every BW+2 cycles.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the bcd2bin core.
//   - FSM state encodings (kept as plain 2-bit constants for compatibility with
//     existing code that compares raw state values)
//   - default operand/result sizing
//   - digit_valid(): true when a 4-bit BCD digit holds 0..9
package bcd2bin_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEF_NDIG = 2;
  localparam int DEF_BW   = 7;

  function automatic logic digit_valid(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step of reverse double-dabble.
// After the right shift, a digit that is >= 8 has picked up a bit worth 8
// that should have been worth 5 (half of ten), so subtract 3.
//   digit  in   4  shifted BCD digit
//   adj    out  4  corrected digit
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Subtraction happens only for values >= 8, so it never wraps.
  assign adj = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd2bin_conv.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// One right shift plus digit correction per cycle; BW cycles per conversion.
// Outputs are registered so the downstream negedge result registers see
// stable data half a cycle after ld_out rises.
//   clk      in   1       clock, rising-edge state updates
//   reset    in   1       synchronous, active-high
//   start    in   1       conversion request, sampled only in IDLE
//   bcd_in   in   4*NDIG  packed BCD operand, digit 0 in [3:0]
//   busy     out  1       high in CONV or DONE
//   done     out  1       one-cycle pulse, bin_out/err valid
//   ld_out   out  1       load strobe, same timing as done
//   bin_out  out  BW      binary result, held until next done
//   err      out  1       invalid digit seen, held until next accepted start
module bcd2bin_conv
  import bcd2bin_pkg::*;
#(
  parameter int NDIG = DEF_NDIG,
  parameter int BW   = DEF_BW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic              ld_out,
  output logic [BW-1:0]     bin_out,
  output logic              err
);

  localparam int DW = 4 * NDIG;
  localparam int SW = DW + BW;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);

  if ((2 ** BW) < (10 ** NDIG)) begin : g_bw_check
    $error("bcd2bin_conv: BW too small to hold 10**NDIG - 1");
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sh;        // {bcd_field, bin_field}
  logic [SW-1:0] sh_shift;
  logic [SW-1:0] sh_next;
  logic [DW-1:0] bcd_adj;
  logic          all_valid;

  assign sh_shift = sh >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (sh_shift[BW + 4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
  end

  // Only the BCD field is corrected; bits already shifted into the binary
  // field are final.
  assign sh_next = {bcd_adj, sh_shift[BW-1:0]};

  always_comb begin
    // NOTE: default assignment first so no path leaves all_valid unassigned,
    // which would otherwise infer a latch.
    all_valid = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!digit_valid(bcd_in[4*i +: 4])) all_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      done    <= 1'b0;
      ld_out  <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      done   <= 1'b0;
      ld_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (all_valid) begin
              sh    <= {bcd_in, {BW{1'b0}}};
              cnt   <= '0;
              err   <= 1'b0;
              state <= CONV;
            end else begin
              // Invalid operand skips conversion entirely.
              err     <= 1'b1;
              bin_out <= '0;
              state   <= DONE;
            end
          end
        end
        CONV: begin
          sh  <= sh_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            bin_out <= sh_next[BW-1:0];
            state   <= DONE;
          end
        end
        DONE: begin
          // Strobes are registered here, so they are high during the cycle
          // after DONE while the FSM is already back in IDLE.
          done   <= 1'b1;
          ld_out <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CONV) || (state == DONE);

  // A complete conversion must have drained every BCD digit.
  always_ff @(posedge clk) begin
    if (!reset && state == CONV && cnt == CNT_LAST) begin
      assert (sh_next[SW-1:BW] == '0)
        else $error("bcd2bin_conv: residual BCD field after conversion");
    end
  end

endmodule

// File: tb/tb_bcd2bin_conv.sv
// Directed self-checking bench for bcd2bin_conv (NDIG=2, BW=7).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_bcd2bin_conv;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       busy, done, ld_out, err;
  logic [6:0] bin_out;

  int tests = 0;
  int fails = 0;

  bcd2bin_conv #(.NDIG(2), .BW(7)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .ld_out  (ld_out),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd_val(input logic [7:0] code);
    return int'(code[7:4]) * 10 + int'(code[3:0]);
  endfunction

  // Issue one start pulse, then wait (bounded) for done. lat counts edges
  // after the accepting edge until done is seen.
  task automatic run_conv(input logic [7:0] code, output logic [6:0] res,
                          output logic e, output int lat, output logic ld_ok);
    start  = 1'b1;
    bcd_in = code;
    step();
    start  = 1'b0;
    bcd_in = 8'h5A;   // operand must already be captured
    lat    = 0;
    ld_ok  = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
      if (ld_out !== done) ld_ok = 1'b0;
    end
    res = bin_out;
    e   = err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    bcd_in = 8'h42;
    step();
    step();
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (ld_out !== 1'b0)  begin fails++; $display("FAIL reset_ld_out: got %b expected 0", ld_out); end
    tests++; if (bin_out !== 7'd0) begin fails++; $display("FAIL reset_bin_out: got %0d expected 0", bin_out); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    start = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [6:0] res; logic e, ld_ok; int lat;
    run_conv(8'h99, res, e, lat, ld_ok);
    tests++; if (lat !== 8)     begin fails++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    tests++; if (res !== 7'd99) begin fails++; $display("FAIL basic_result: got %0d expected 99", res); end
    tests++; if (e !== 1'b0)    begin fails++; $display("FAIL basic_err: got %b expected 0", e); end
    tests++; if (ld_ok !== 1'b1) begin fails++; $display("FAIL basic_ld_out: ld_out not coincident with done"); end
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width: got %b expected 0", done); end
  endtask

  task automatic test_directed();
    logic [6:0] res; logic e, ld_ok; int lat;
    logic [7:0] codes [3] = '{8'h00, 8'h45, 8'h10};
    logic [6:0] exps  [3] = '{7'd0, 7'd45, 7'd10};
    for (int i = 0; i < 3; i++) begin
      run_conv(codes[i], res, e, lat, ld_ok);
      tests++;
      if (res !== exps[i] || e !== 1'b0 || lat !== 8) begin
        fails++;
        $display("FAIL directed_%h: got %0d err=%b lat=%0d expected %0d err=0 lat=8",
                 codes[i], res, e, lat, exps[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [6:0] res; logic e, ld_ok; int lat;
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        logic [7:0] code;
        code = {4'(t), 4'(u)};
        run_conv(code, res, e, lat, ld_ok);
        tests++;
        if (int'(res) != bcd_val(code) || e !== 1'b0 || ld_ok !== 1'b1) begin
          fails++;
          $display("FAIL sweep_%h: got %0d err=%b expected %0d err=0", code, res, e, bcd_val(code));
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] res; logic e, ld_ok; int lat;
    run_conv(8'h3A, res, e, lat, ld_ok);
    tests++; if (lat !== 1)     begin fails++; $display("FAIL invalid_latency: got %0d expected 1", lat); end
    tests++; if (e !== 1'b1)    begin fails++; $display("FAIL invalid_err: got %b expected 1", e); end
    tests++; if (res !== 7'd0)  begin fails++; $display("FAIL invalid_result: got %0d expected 0", res); end
    step(); step();
    tests++; if (err !== 1'b1)  begin fails++; $display("FAIL invalid_err_hold: got %b expected 1", err); end
    run_conv(8'h05, res, e, lat, ld_ok);
    tests++; if (e !== 1'b0)    begin fails++; $display("FAIL invalid_err_clear: got %b expected 0", e); end
    tests++; if (res !== 7'd5)  begin fails++; $display("FAIL invalid_next_result: got %0d expected 5", res); end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int first = -1;
    start = 1'b1; bcd_in = 8'h63;
    step();                      // accepted
    start = 1'b0; bcd_in = 8'h00;
    step(); step();              // CONV cycles 1..2
    start = 1'b1; bcd_in = 8'h21;
    step();                      // CONV cycle 3: must be ignored
    start = 1'b0;
    for (int c = 4; c < 24; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c - 1;
        tests++;
        if (bin_out !== 7'd63) begin fails++; $display("FAIL ignore_result: got %0d expected 63", bin_out); end
      end
      step();
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    tests++; if (first !== 8) begin fails++; $display("FAIL ignore_latency: got %0d expected 8", first); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] res; logic e, ld_ok; int lat;
    int nstrobe = 0;
    start = 1'b1; bcd_in = 8'h88;
    step();
    start = 1'b0;
    step(); step(); step();      // CONV cycles 1..3
    reset = 1'b1;
    step();                      // reset on CONV cycle 4
    reset = 1'b0;
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    tests++; if (bin_out !== 7'd0) begin fails++; $display("FAIL midreset_bin_out: got %0d expected 0", bin_out); end
    for (int c = 0; c < 12; c++) begin
      if (done !== 1'b0 || ld_out !== 1'b0) nstrobe++;
      step();
    end
    tests++; if (nstrobe !== 0) begin fails++; $display("FAIL midreset_strobe: got %0d strobes expected 0", nstrobe); end
    run_conv(8'h27, res, e, lat, ld_ok);
    tests++; if (res !== 7'd27 || lat !== 8) begin
      fails++; $display("FAIL midreset_next: got %0d lat=%0d expected 27 lat=8", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int times [$];
    start = 1'b1; bcd_in = 8'h12;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done === 1'b1) begin
        times.push_back(c);
        tests++;
        if (bin_out !== 7'd12) begin fails++; $display("FAIL b2b_result: got %0d expected 12", bin_out); end
      end
    end
    start = 1'b0;
    tests++; if (times.size() < 3) begin
      fails++; $display("FAIL b2b_count: got %0d dones expected at least 3", times.size());
    end
    for (int i = 1; i < times.size(); i++) begin
      tests++;
      if (times[i] - times[i-1] != 9) begin
        fails++; $display("FAIL b2b_period: got %0d expected 9", times[i] - times[i-1]);
      end
    end
    for (int c = 0; c < 12; c++) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_sweep();
    test_invalid();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
